// File: rtl/uart_pkg.sv
// uart_pkg: shared 8N1 UART FSM states, frame constants and baud divisor helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy and full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [AW:0]      count_next;

    // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle
    assign rd_ok      = rd_en && !empty;
    assign wr_ok      = wr_en && (!full || rd_ok);
    assign count_next = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    assign rd_data    = mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two depth; flags track the next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_ok);
            rd_ptr <= rd_ptr + AW'(rd_ok);
            count  <= count_next;
            full   <= count_next == (AW+1)'(DEPTH);
            empty  <= count_next == '0;
        end
    end

    // Storage array, left unreset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from an internal byte FIFO
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic [2:0]                  state
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;

    uart_state_t cur;
    uart_state_t nxt;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic [7:0]    head;
    logic          pop;
    logic          baud_end;
    logic          tx_next;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_valid),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end = baud == CW'(CPB - 1);
    assign busy     = cur != IDLE || !fifo_empty;
    assign state    = cur;

    // Next state, FIFO pop and done pulse; the stop bit chains straight into the next start bit
    always_comb begin
        nxt     = cur;
        pop     = 1'b0;
        tx_done = 1'b0;
        case (cur)
            IDLE: begin
                pop = !fifo_empty;
                nxt = fifo_empty ? IDLE : START;
            end
            START: nxt = baud_end ? DATA : START;
            DATA:  nxt = (baud_end && bit_idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
            STOP: begin
                tx_done = baud_end;
                pop     = baud_end && !fifo_empty;
                nxt     = !baud_end ? STOP : fifo_empty ? IDLE : START;
            end
            default: nxt = IDLE;
        endcase
        tx_next = nxt == START ? 1'b0 :
                  nxt == DATA  ? ((cur == DATA && baud_end) ? sh[1] : sh[0]) : 1'b1;
    end

    // State, baud counter, shift register and registered line driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            cur     <= nxt;
            tx      <= tx_next;
            baud    <= (cur == IDLE || baud_end) ? '0 : baud + CW'(1);
            bit_idx <= cur != DATA ? 3'd0 : baud_end ? bit_idx + 3'd1 : bit_idx;
            sh      <= pop ? head : (cur == DATA && baud_end) ? sh >> 1 : sh;
        end
    end

    // Sticky flag for a write dropped because the FIFO was full and nothing was popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (data_valid && fifo_full && !pop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a short bit period
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       tx, busy, tx_done, fifo_full, fifo_empty, overflow;
    logic [4:0] fifo_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bytes(input logic [7:0] q[$], output int peak);
        peak = 0;
        foreach (q[i]) begin
            data_valid = 1'b1;
            data_in    = q[i];
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 50*CPB) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(tx), 0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] f;
        int good[10];
        int dn, dpos;
        f = {1'b1, b, 1'b0};
        dn = 0;
        dpos = -1;
        for (int k = 0; k < 10; k++) good[k] = 0;
        for (int i = 0; i < 10*CPB; i++) begin
            if (tx === f[i/CPB]) good[i/CPB]++;
            if (tx_done === 1'b1) begin
                dn++;
                dpos = i;
            end
            if (i < 10*CPB-1) tick();
        end
        for (int k = 0; k < 10; k++) check($sformatf("%s_bit%0d", tag, k), good[k], CPB);
        check({tag, "_done_cnt"}, dn, 1);
        check({tag, "_done_pos"}, dpos, 10*CPB-1);
    endtask

    task automatic expect_frames(input string tag, input logic [7:0] q[$]);
        wait_start(tag);
        foreach (q[i]) begin
            check_frame($sformatf("%s_f%0d", tag, i), q[i]);
            tick();
            if (i < q.size()-1) check($sformatf("%s_gap%0d", tag, i), 32'(tx), 0);
        end
        check({tag, "_end_busy"}, 32'(busy), 0);
        check({tag, "_end_state"}, 32'(state), 0);
        check({tag, "_end_tx"}, 32'(tx), 1);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] e[$];
        int peak, bad, n;

        repeat (3) tick();
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_state", 32'(state), 0);
        rst_n = 1'b1;

        bad = 0;
        data_in = 8'hFF;
        repeat (2000) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1 || state !== 3'd0) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        data_valid = 1'b1;
        data_in = 8'h55;
        tick();
        data_valid = 1'b0;
        check("single_count", 32'(fifo_count), 1);
        check("single_latency_tx", 32'(tx), 1);
        check("single_busy", 32'(busy), 1);
        tick();
        check("single_tx_low", 32'(tx), 0);
        check("single_state", 32'(state), 1);
        check("single_popped", 32'(fifo_count), 0);
        check_frame("single", 8'h55);
        tick();
        check("single_busy_drop", 32'(busy), 0);
        check("single_idle", 32'(state), 0);
        check("single_tx_high", 32'(tx), 1);
        check("single_done_low", 32'(tx_done), 0);

        q = {8'h41, 8'h42, 8'h43};
        fork
            write_bytes(q, peak);
            expect_frames("abc", q);
        join

        q.delete();
        e.delete();
        for (int i = 0; i < 18; i++) q.push_back(8'(i));
        for (int i = 0; i < 17; i++) e.push_back(8'(i));
        fork
            write_bytes(q, peak);
            expect_frames("ovf", e);
        join
        check("ovf_peak", peak, 16);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drained", 32'(fifo_count), 0);

        rst_n = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        q.delete();
        e.delete();
        for (int i = 0; i < 17; i++) q.push_back(8'(8'h20 + i));
        for (int i = 1; i < 17; i++) e.push_back(8'(8'h20 + i));
        e.push_front(8'h20);
        e.push_back(8'hA5);
        fork
            begin
                write_bytes(q, peak);
                check("fp_full_count", 32'(fifo_count), 16);
                check("fp_full_flag", 32'(fifo_full), 1);
                n = 0;
                while (tx_done !== 1'b1 && n < 20*CPB) begin
                    tick();
                    n++;
                end
                check("fp_done_seen", 32'(tx_done), 1);
                data_valid = 1'b1;
                data_in = 8'hA5;
                tick();
                data_valid = 1'b0;
                check("fp_count_kept", 32'(fifo_count), 16);
                check("fp_no_ovf", 32'(overflow), 0);
                check("fp_still_full", 32'(fifo_full), 1);
            end
            expect_frames("fp", e);
        join
        check("fp_end_ovf", 32'(overflow), 0);

        q = {8'h00, 8'h00, 8'h00, 8'h00};
        write_bytes(q, peak);
        repeat (42) tick();
        check("mid_pre_state", 32'(state), 2);
        check("mid_pre_tx", 32'(tx), 0);
        check("mid_pre_count", 32'(fifo_count), 3);
        rst_n = 1'b0;
        #1;
        check("mid_async_tx", 32'(tx), 1);
        check("mid_count", 32'(fifo_count), 0);
        check("mid_state", 32'(state), 0);
        check("mid_empty", 32'(fifo_empty), 1);
        #2;
        rst_n = 1'b1;
        bad = 0;
        repeat (30*CPB) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_quiet_cycles", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
